// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit seven-segment scan controller
// with CPU/debug source arbitration and leading-zero blanking.
//   clk, reset_n       : clock, async active-low reset
//   wb_valid, wb_data  : CPU write-back strobe and value
//   dbg_req, dbg_data  : debug takeover request and value
//   dbg_ack            : one-cycle pulse on accepted request
//   blank_lz           : leading-zero blanking, CPU source only
//   enable, digit, src : active-low digit enables, nibble, source
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_FRAMES = 250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  logic [15:0] wb_data,
  input  logic        dbg_req,
  input  logic [15:0] dbg_data,
  output logic        dbg_ack,
  input  logic        blank_lz,
  output logic [3:0]  enable,
  output logic [3:0]  digit,
  output logic        src
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT =
    HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    S0, S1, S2, S3
  } scan_t;

  typedef enum logic {
    SHOW_CPU, SHOW_DBG
  } mode_t;

  logic [CW-1:0] cnt;
  logic          tick;
  logic          frame_done;
  scan_t         scan, scan_nx;
  mode_t         mode, mode_nx;
  logic [HW-1:0] hold, hold_nx;
  logic [15:0]   cpu_reg;
  logic [15:0]   dbg_reg, dbg_nx;
  logic          ack_nx;
  logic [15:0]   word;
  logic [3:0]    lz;
  logic          blank;

  // prescaler
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick       = (cnt == CNT_MAX);
  assign frame_done = tick && (scan == S3);

  // scan FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan <= S0;
    end else begin
      scan <= scan_nx;
    end
  end

  always_comb begin
    scan_nx = scan;
    if (tick) begin
      unique case (scan)
        S0: scan_nx = S1;
        S1: scan_nx = S2;
        S2: scan_nx = S3;
        S3: scan_nx = S0;
      endcase
    end
  end

  // CPU value always tracks write-back, in any mode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_reg <= '0;
    end else if (wb_valid) begin
      cpu_reg <= wb_data;
    end
  end

  // mode FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode    <= SHOW_CPU;
      hold    <= '0;
      dbg_reg <= '0;
      dbg_ack <= 1'b0;
    end else begin
      mode    <= mode_nx;
      hold    <= hold_nx;
      dbg_reg <= dbg_nx;
      dbg_ack <= ack_nx;
    end
  end

  // The frame in progress at acceptance is frame 1,
  // so the hold ends on the HOLD_FRAMES-th frame_done.
  always_comb begin
    mode_nx = mode;
    hold_nx = hold;
    dbg_nx  = dbg_reg;
    ack_nx  = 1'b0;
    unique case (mode)
      SHOW_CPU: begin
        if (dbg_req) begin
          mode_nx = SHOW_DBG;
          hold_nx = HOLD_INIT;
          dbg_nx  = dbg_data;
          ack_nx  = 1'b1;
        end
      end
      SHOW_DBG: begin
        if (frame_done) begin
          if (hold == HW'(1)) begin
            mode_nx = SHOW_CPU;
          end else begin
            hold_nx = hold - HW'(1);
          end
        end
      end
    endcase
  end

  // slot outputs
  assign src  = (mode == SHOW_DBG);
  assign word = src ? dbg_reg : cpu_reg;

  // lz[i]: nibbles i..3 of the CPU word are zero
  assign lz = {
    cpu_reg[15:12] == 4'h0,
    cpu_reg[15:8]  == 8'h00,
    cpu_reg[15:4]  == 12'h000,
    1'b0
  };

  assign blank = blank_lz && !src && lz[scan];

  always_comb begin
    digit  = word[3:0];
    enable = 4'b1110;
    unique case (scan)
      S0: begin
        digit  = word[3:0];
        enable = 4'b1110;
      end
      S1: begin
        digit  = word[7:4];
        enable = 4'b1101;
      end
      S2: begin
        digit  = word[11:8];
        enable = 4'b1011;
      end
      S3: begin
        digit  = word[15:12];
        enable = 4'b0111;
      end
    endcase
    if (blank) begin
      enable = 4'b1111;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed bench with a cycle-level
// reference model of display_scan_ctrl.
module tb_display_scan_ctrl;

  localparam int RD = 4;
  localparam int HF = 2;
  localparam int FRAME = 4 * RD;

  logic        clk;
  logic        reset_n;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        dbg_req;
  logic [15:0] dbg_data;
  logic        dbg_ack;
  logic        blank_lz;
  logic [3:0]  enable;
  logic [3:0]  digit;
  logic        src;

  int total = 0;
  int bad   = 0;

  display_scan_ctrl #(
    .REFRESH_DIV(RD),
    .HOLD_FRAMES(HF)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wb_valid (wb_valid),
    .wb_data  (wb_data),
    .dbg_req  (dbg_req),
    .dbg_data (dbg_data),
    .dbg_ack  (dbg_ack),
    .blank_lz (blank_lz),
    .enable   (enable),
    .digit    (digit),
    .src      (src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: e = edges since reset release; the slot is
  // e/RD mod 4 and frame ends fall on multiples of FRAME
  int          e     = 0;
  int          end_e = 0;
  logic        m_dbg = 1'b0;
  logic        m_ack = 1'b0;
  logic [15:0] m_cpu = '0;
  logic [15:0] m_val = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e     = 0;
      end_e = 0;
      m_dbg = 1'b0;
      m_ack = 1'b0;
      m_cpu = '0;
      m_val = '0;
    end else begin
      e     = e + 1;
      m_ack = 1'b0;
      if (wb_valid) m_cpu = wb_data;
      if (m_dbg) begin
        if (e == end_e) m_dbg = 1'b0;
      end else if (dbg_req) begin
        m_dbg = 1'b1;
        m_ack = 1'b1;
        m_val = dbg_data;
        end_e = (e / FRAME + HF) * FRAME;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int          slot;
    logic [15:0] shown;
    logic [3:0]  x_dig;
    logic [3:0]  x_en;
    logic        blk;
    #1;
    slot  = (e / RD) % 4;
    shown = m_dbg ? m_val : m_cpu;
    x_dig = 4'((shown >> (4 * slot)) & 16'hF);
    blk   = blank_lz && !m_dbg && slot > 0 &&
            ((m_cpu >> (4 * slot)) == 16'h0);
    x_en  = blk ? 4'hF : ~(4'b0001 << slot);
    chk("model_enable", {12'h0, enable}, {12'h0, x_en});
    chk("model_digit", {12'h0, digit}, {12'h0, x_dig});
    chk("model_src", {15'h0, src}, {15'h0, m_dbg});
    chk("model_ack", {15'h0, dbg_ack}, {15'h0, m_ack});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    wb_valid = 1'b0;
    dbg_req  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic lit(input string nm,
                     input logic [3:0] x_en,
                     input logic [3:0] x_dig,
                     input logic x_src,
                     input logic x_ack);
    chk({nm, "_en"}, {12'h0, enable}, {12'h0, x_en});
    chk({nm, "_dig"}, {12'h0, digit}, {12'h0, x_dig});
    chk({nm, "_src"}, {15'h0, src}, {15'h0, x_src});
    chk({nm, "_ack"}, {15'h0, dbg_ack}, {15'h0, x_ack});
  endtask

  // load v on edge 1, then visit slots 0..3
  task automatic scan_lit(input string nm,
                          input logic [15:0] v,
                          input logic bl,
                          input logic [15:0] x_en,
                          input logic [15:0] x_dig);
    do_reset();
    blank_lz = bl;
    wb_valid = 1'b1;
    wb_data  = v;
    for (int s = 0; s < 4; s++) begin
      cyc(s == 0 ? 1 : (s == 1 ? RD - 1 : RD));
      wb_valid = 1'b0;
      lit($sformatf("%s_s%0d", nm, s),
          x_en[4*s +: 4], x_dig[4*s +: 4], 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    wb_valid = 1'b0;
    wb_data  = '0;
    dbg_req  = 1'b0;
    dbg_data = '0;
    blank_lz = 1'b0;

    // reset values and first slot change
    cyc(2);
    lit("rst", 4'b1110, 4'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cyc(RD - 1);
    lit("pre_slot1", 4'b1110, 4'h0, 1'b0, 1'b0);
    cyc(1);
    lit("slot1", 4'b1101, 4'h0, 1'b0, 1'b0);

    // scan order and blanking
    scan_lit("scan", 16'h1A3F, 1'b0, 16'h7BDE, 16'h1A3F);
    cyc(RD);
    lit("wrap", 4'b1110, 4'hF, 1'b0, 1'b0);
    scan_lit("lz5", 16'h0005, 1'b1, 16'hFFFE, 16'h0005);
    scan_lit("lz0", 16'h0000, 1'b1, 16'hFFFE, 16'h0000);
    scan_lit("lz300", 16'h0300, 1'b1, 16'hFBDE, 16'h0300);

    // debug takeover, accepted on edge 3
    do_reset();
    blank_lz = 1'b0;
    wb_valid = 1'b1;
    wb_data  = 16'h1234;
    cyc(1);
    wb_valid = 1'b0;
    cyc(1);
    dbg_req  = 1'b1;
    dbg_data = 16'hBEEF;
    cyc(1);
    dbg_req = 1'b0;
    lit("dbg_e3", 4'b1110, 4'hF, 1'b1, 1'b1);
    cyc(1);
    lit("dbg_e4", 4'b1101, 4'hE, 1'b1, 1'b0);
    wb_valid = 1'b1;
    wb_data  = 16'h5678;
    cyc(1);
    wb_valid = 1'b0;
    cyc(3);
    lit("dbg_e8", 4'b1011, 4'hE, 1'b1, 1'b0);
    cyc(4);
    lit("dbg_e12", 4'b0111, 4'hB, 1'b1, 1'b0);
    cyc(19);
    lit("dbg_e31", 4'b0111, 4'hB, 1'b1, 1'b0);
    cyc(1);
    lit("ret_e32", 4'b1110, 4'h8, 1'b0, 1'b0);
    cyc(4);
    lit("ret_e36", 4'b1101, 4'h7, 1'b0, 1'b0);
    cyc(4);
    lit("ret_e40", 4'b1011, 4'h6, 1'b0, 1'b0);
    cyc(4);
    lit("ret_e44", 4'b0111, 4'h5, 1'b0, 1'b0);

    // contention, request held through the hold
    do_reset();
    wb_valid = 1'b1;
    wb_data  = 16'h1111;
    dbg_req  = 1'b1;
    dbg_data = 16'h2222;
    cyc(1);
    wb_valid = 1'b0;
    lit("both_e1", 4'b1110, 4'h2, 1'b1, 1'b1);
    cyc(1);
    lit("hold_e2", 4'b1110, 4'h2, 1'b1, 1'b0);
    cyc(18);
    lit("hold_e20", 4'b1101, 4'h2, 1'b1, 1'b0);
    cyc(11);
    lit("hold_e31", 4'b0111, 4'h2, 1'b1, 1'b0);
    cyc(1);
    lit("back_e32", 4'b1110, 4'h1, 1'b0, 1'b0);
    cyc(1);
    lit("reacc_e33", 4'b1110, 4'h2, 1'b1, 1'b1);
    cyc(5);

    // async reset between edges, mid-hold
    dbg_data = 16'h3333;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    lit("arst", 4'b1110, 4'h0, 1'b0, 1'b0);
    cyc(2);
    lit("arst_hold", 4'b1110, 4'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cyc(1);
    lit("arst_acc", 4'b1110, 4'h3, 1'b1, 1'b1);
    dbg_req = 1'b0;
    cyc(1);
    lit("arst_ack_off", 4'b1110, 4'h3, 1'b1, 1'b0);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
